de_pipe_reg: RTL and testbench
==============================

# de_pipe_reg

- Decode-to-Execute pipeline register of the five-stage CPU.
- Captures the 32-bit extended immediate produced by the D-stage immediate extender, together with the instruction word, PC, forwarded register operands, hazard timing and exception information, and presents them to the E stage one cycle later.
- Implements the stall-bubble and exception-flush behaviour the hazard unit and CP0 require, including the EPC/BD preservation that precise exceptions depend on.

## Interface

Parameters:
- `PC_RESET`, default 32'h0000_3000: value of `pc_E` after reset and after flush.

Ports:
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `stall`  input  1  D stage held by the hazard unit; E receives a bubble.
- `flush`  input  1  exception entry or ERET; E is cleared.
- `instr_D`  input  32  instruction word in D.
- `pc_D`  input  32  PC of instruction in D.
- `rs_data_D`  input  32  forwarded rs operand.
- `rt_data_D`  input  32  forwarded rt operand.
- `ext_D`  input  32  extended immediate from the D-stage extender.
- `tnew_D`  input  2  cycles until result ready, counted from D (0..3).
- `bd_D`  input  1  instruction in D sits in a branch delay slot.
- `exccode_D`  input  5  exception code raised in F/D; 0 = none.
- `instr_E`, `pc_E`, `rs_data_E`, `rt_data_E`, `ext_E`  output  32 each  registered copies.
- `tnew_E`  output  2  E-relative Tnew.
- `bd_E`  output  1  registered delay-slot flag.
- `exccode_E`  output  5  registered exception code.
- `valid_E`  output  1  1 = real instruction in E, 0 = bubble or cleared.

## Operation

Each rising edge applies exactly one action, chosen by priority reset > flush > stall > load.

- **reset:**
  - All outputs go to 0, except `pc_E` = `PC_RESET`.
  - `instr_E` = 32'h0 (sll $0,$0,0 = nop).
- **flush:**
  - Same values as reset, regardless of `stall`.
  - Flush always wins over stall.
- **stall** (without flush): the E register becomes a bubble.
  - `instr_E`, `rs_data_E`, `rt_data_E`, `ext_E` = 0.
  - `tnew_E` = 0, `exccode_E` = 0, `valid_E` = 0.
  - `pc_E` and `bd_E` follow the Configuration section.
- **load** (neither stall nor flush):
  - All D inputs are captured and `valid_E` = 1.
  - `tnew_E` = `tnew_D` − 1, saturating at 0 (inputs 0 and 1 both give 0; 3 gives 2).
- `ext_D` is stored bit-exact; no re-extension or width change takes place here.
- An exception code is carried unchanged: a nonzero `exccode_D` loads with `valid_E` = 1, so CP0 sees it in M.
- The block holds no state beyond the output registers and has no internal FSM. Its state is effectively {VALID, BUBBLE}, with transitions given by the priority rules above.

## Timing

- Latency is 1 cycle: D values present before edge N appear on the outputs after edge N.
- All outputs come directly from flops; there is no combinational path from input to output.
- `stall` and `flush` are sampled at the same edge as the data.
  - A stall asserted for k consecutive cycles inserts k bubbles.
  - The instruction held in D loads on the first edge with `stall` = 0.
- Reset asserted mid-stream takes effect at the next edge. Any in-flight instruction is discarded and `valid_E` = 0 in the following cycle.
- Reset deasserted: the first load can occur on the next edge.

## Configuration

- Macro `DE_BUBBLE_PC_KEEP_EN`.
- **Defined:**
  - A stall bubble takes `pc_E` = `pc_D` and `bd_E` = `bd_D`.
  - An interrupt sampled while the bubble is in M therefore reports a correct EPC and BD for the stalled instruction.
- **Undefined:**
  - A stall bubble takes `pc_E` = `PC_RESET` and `bd_E` = 0.
  - EPC for interrupts on bubbles is then derived elsewhere.
- Reset and flush values are identical in both builds.

## Test plan

- **Reset:** assert `reset` with arbitrary D inputs for one edge, then deassert.
  - Required: `pc_E` = 32'h0000_3000, all other outputs 0, `valid_E` = 0.
- **Load:** `instr_D` = 32'h3C01_1234, `pc_D` = 32'h0000_3004, `ext_D` = 32'hFFFF_8000, `tnew_D` = 2.
  - Required after one edge: identical values on the E outputs, `tnew_E` = 1, `valid_E` = 1.
- **Stall:** hold `stall` = 1 for 2 cycles with `pc_D` = 32'h0000_3008 and `bd_D` = 1.
  - Required: two bubbles with `instr_E` = 0 and `valid_E` = 0.
  - With the macro: `pc_E` = 32'h0000_3008, `bd_E` = 1. Without it: `pc_E` = 32'h0000_3000, `bd_E` = 0.
  - The third edge, with `stall` = 0, loads the held instruction.
- **Flush over stall:** `stall` = 1 and `flush` = 1 on the same edge.
  - Required: flush values, including `pc_E` = 32'h0000_3000 even with the macro defined.
- **Exception carry:** `exccode_D` = 5'd10 (RI) with `tnew_D` = 0.
  - Required: `exccode_E` = 10, `valid_E` = 1, `tnew_E` = 0.
- **Reset mid-stream:** reset asserted while a valid instruction is in E.
  - Required: next cycle `valid_E` = 0 and `exccode_E` = 0.

Source files
------------

// File: rtl/de_pipe_if.sv
// Decode-to-Execute bundle: D-stage inputs, hazard/CP0 controls and registered E-stage outputs.
// master drives the D side and observes E; slave is the pipeline register itself.
interface de_pipe_if;
    logic        stall;
    logic        flush;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] rs_data_D;
    logic [31:0] rt_data_D;
    logic [31:0] ext_D;
    logic [1:0]  tnew_D;
    logic        bd_D;
    logic [4:0]  exccode_D;
    logic [31:0] instr_E;
    logic [31:0] pc_E;
    logic [31:0] rs_data_E;
    logic [31:0] rt_data_E;
    logic [31:0] ext_E;
    logic [1:0]  tnew_E;
    logic        bd_E;
    logic [4:0]  exccode_E;
    logic        valid_E;

    modport master (
        output stall, flush, instr_D, pc_D, rs_data_D, rt_data_D, ext_D,
               tnew_D, bd_D, exccode_D,
        input  instr_E, pc_E, rs_data_E, rt_data_E, ext_E, tnew_E, bd_E,
               exccode_E, valid_E
    );

    modport slave (
        input  stall, flush, instr_D, pc_D, rs_data_D, rt_data_D, ext_D,
               tnew_D, bd_D, exccode_D,
        output instr_E, pc_E, rs_data_E, rt_data_E, ext_E, tnew_E, bd_E,
               exccode_E, valid_E
    );
endinterface

// File: rtl/de_pipe_reg.sv
// D->E pipeline register with stall bubbles and flush (priority reset > flush > stall > load).
// Optional macro DE_BUBBLE_PC_KEEP_EN: stall bubbles keep pc_D/bd_D so EPC/BD stay precise.
module de_pipe_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic     clk,
    input  logic     reset,
    de_pipe_if.slave bus
);

    logic [31:0] instr_d, instr_q;
    logic [31:0] pc_d, pc_q;
    logic [31:0] rs_data_d, rs_data_q;
    logic [31:0] rt_data_d, rt_data_q;
    logic [31:0] ext_d, ext_q;
    logic [1:0]  tnew_d, tnew_q;
    logic        bd_d, bd_q;
    logic [4:0]  exccode_d, exccode_q;
    logic        valid_d, valid_q;

    // Tnew is counted from D, so E sees one cycle less, never below zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : (t - 2'd1);
    endfunction

    // Next-state selection among flush, stall bubble and load.
    always_comb begin
        instr_d   = 32'h0000_0000;
        pc_d      = PC_RESET;
        rs_data_d = 32'h0000_0000;
        rt_data_d = 32'h0000_0000;
        ext_d     = 32'h0000_0000;
        tnew_d    = 2'd0;
        bd_d      = 1'b0;
        exccode_d = 5'd0;
        valid_d   = 1'b0;
        if (bus.flush) begin
            pc_d = PC_RESET;
            bd_d = 1'b0;
        end else if (bus.stall) begin
`ifdef DE_BUBBLE_PC_KEEP_EN
            pc_d = bus.pc_D;
            bd_d = bus.bd_D;
`else
            pc_d = PC_RESET;
            bd_d = 1'b0;
`endif
        end else begin
            instr_d   = bus.instr_D;
            pc_d      = bus.pc_D;
            rs_data_d = bus.rs_data_D;
            rt_data_d = bus.rt_data_D;
            ext_d     = bus.ext_D;
            tnew_d    = tnew_dec(bus.tnew_D);
            bd_d      = bus.bd_D;
            exccode_d = bus.exccode_D;
            valid_d   = 1'b1;
        end
    end

    // E-stage register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= 32'h0000_0000;
            pc_q      <= PC_RESET;
            rs_data_q <= 32'h0000_0000;
            rt_data_q <= 32'h0000_0000;
            ext_q     <= 32'h0000_0000;
            tnew_q    <= 2'd0;
            bd_q      <= 1'b0;
            exccode_q <= 5'd0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            ext_q     <= ext_d;
            tnew_q    <= tnew_d;
            bd_q      <= bd_d;
            exccode_q <= exccode_d;
            valid_q   <= valid_d;
        end
    end

    assign bus.instr_E   = instr_q;
    assign bus.pc_E      = pc_q;
    assign bus.rs_data_E = rs_data_q;
    assign bus.rt_data_E = rt_data_q;
    assign bus.ext_E     = ext_q;
    assign bus.tnew_E    = tnew_q;
    assign bus.bd_E      = bd_q;
    assign bus.exccode_E = exccode_q;
    assign bus.valid_E   = valid_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Scoreboard bench for de_pipe_reg: driver pushes hand-computed E values per edge, monitor pops and compares.
module tb_de_pipe_reg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [1:0]  tnew;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
    } exp_t;

    localparam logic [31:0] PCR = 32'h0000_3000;
`ifdef DE_BUBBLE_PC_KEEP_EN
    localparam logic [31:0] BPC_A = 32'h0000_3008;
    localparam logic        BBD_A = 1'b1;
    localparam logic [31:0] BPC_B = 32'h0000_3020;
`else
    localparam logic [31:0] BPC_A = 32'h0000_3000;
    localparam logic        BBD_A = 1'b0;
    localparam logic [31:0] BPC_B = 32'h0000_3000;
`endif

    logic clk;
    logic reset;
    de_pipe_if bus ();

    de_pipe_reg #(.PC_RESET(32'h0000_3000)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    exp_t mon_e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    // Monitor: every registered E output set is compared against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("instr_E",   bus.instr_E,           mon_e.instr);
            chk("pc_E",      bus.pc_E,              mon_e.pc);
            chk("rs_data_E", bus.rs_data_E,         mon_e.rs);
            chk("rt_data_E", bus.rt_data_E,         mon_e.rt);
            chk("ext_E",     bus.ext_E,             mon_e.ext);
            chk("tnew_E",    {30'd0, bus.tnew_E},   {30'd0, mon_e.tnew});
            chk("bd_E",      {31'd0, bus.bd_E},     {31'd0, mon_e.bd});
            chk("exccode_E", {27'd0, bus.exccode_E},{27'd0, mon_e.exc});
            chk("valid_E",   {31'd0, bus.valid_E},  {31'd0, mon_e.valid});
        end
    end

    task automatic edge_vec(input logic r, input logic f, input logic s,
                            input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] ext, input logic [1:0] tn,
                            input logic bd, input logic [4:0] ex, input exp_t e);
        @(negedge clk);
        reset         = r;
        bus.flush     = f;
        bus.stall     = s;
        bus.instr_D   = ins;
        bus.pc_D      = pc;
        bus.rs_data_D = rs;
        bus.rt_data_D = rt;
        bus.ext_D     = ext;
        bus.tnew_D    = tn;
        bus.bd_D      = bd;
        bus.exccode_D = ex;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b1; bus.flush = 1'b0; bus.stall = 1'b0;
        bus.instr_D = 32'h0; bus.pc_D = 32'h0; bus.rs_data_D = 32'h0; bus.rt_data_D = 32'h0;
        bus.ext_D = 32'h0; bus.tnew_D = 2'd0; bus.bd_D = 1'b0; bus.exccode_D = 5'd0;

        // reset with arbitrary D inputs
        edge_vec(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234, 32'h1, 32'h2, 32'h3, 2'd3, 1'b1, 5'd5,
                 '{32'h0, PCR, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0});
        // load lui
        edge_vec(1'b0, 1'b0, 1'b0, 32'h3C01_1234, 32'h0000_3004, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_8000, 2'd2, 1'b0, 5'd0,
                 '{32'h3C01_1234, 32'h0000_3004, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_8000, 2'd1, 1'b0, 5'd0, 1'b1});
        // two stall bubbles, then the held instruction loads
        edge_vec(1'b0, 1'b0, 1'b1, 32'h8C22_0004, 32'h0000_3008, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_0004, 2'd3, 1'b1, 5'd0,
                 '{32'h0, BPC_A, 32'h0, 32'h0, 32'h0, 2'd0, BBD_A, 5'd0, 1'b0});
        edge_vec(1'b0, 1'b0, 1'b1, 32'h8C22_0004, 32'h0000_3008, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_0004, 2'd3, 1'b1, 5'd0,
                 '{32'h0, BPC_A, 32'h0, 32'h0, 32'h0, 2'd0, BBD_A, 5'd0, 1'b0});
        edge_vec(1'b0, 1'b0, 1'b0, 32'h8C22_0004, 32'h0000_3008, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_0004, 2'd3, 1'b1, 5'd0,
                 '{32'h8C22_0004, 32'h0000_3008, 32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_0004, 2'd2, 1'b1, 5'd0, 1'b1});
        // flush wins over stall
        edge_vec(1'b0, 1'b1, 1'b1, 32'h0123_4567, 32'h0000_300C, 32'h9, 32'hA, 32'hB, 2'd2, 1'b1, 5'd3,
                 '{32'h0, PCR, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0});
        // exception carry (RI) with tnew 0
        edge_vec(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_3010, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd10,
                 '{32'hFFFF_FFFF, 32'h0000_3010, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd10, 1'b1});
        // tnew 1 saturates to 0
        edge_vec(1'b0, 1'b0, 1'b0, 32'h0043_0820, 32'h0000_3014, 32'h5, 32'h6, 32'h0000_0820, 2'd1, 1'b0, 5'd0,
                 '{32'h0043_0820, 32'h0000_3014, 32'h5, 32'h6, 32'h0000_0820, 2'd0, 1'b0, 5'd0, 1'b1});
        // flush alone
        edge_vec(1'b0, 1'b1, 1'b0, 32'h2401_0001, 32'h0000_3018, 32'h7, 32'h8, 32'h1, 2'd3, 1'b1, 5'd4,
                 '{32'h0, PCR, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0});
        // load tnew 3 with exception code, then reset mid-stream
        edge_vec(1'b0, 1'b0, 1'b0, 32'h2401_7FFF, 32'h0000_3018, 32'hC, 32'hD, 32'h0000_7FFF, 2'd3, 1'b0, 5'd4,
                 '{32'h2401_7FFF, 32'h0000_3018, 32'hC, 32'hD, 32'h0000_7FFF, 2'd2, 1'b0, 5'd4, 1'b1});
        edge_vec(1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_301C, 32'hE, 32'hF, 32'h10, 2'd2, 1'b1, 5'd12,
                 '{32'h0, PCR, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0});
        // first load right after reset release
        edge_vec(1'b0, 1'b0, 1'b0, 32'h1000_FFFF, 32'h0000_301C, 32'h7, 32'h8, 32'hFFFF_FFFF, 2'd0, 1'b0, 5'd0,
                 '{32'h1000_FFFF, 32'h0000_301C, 32'h7, 32'h8, 32'hFFFF_FFFF, 2'd0, 1'b0, 5'd0, 1'b1});
        // stall with bd_D = 0
        edge_vec(1'b0, 1'b0, 1'b1, 32'h0000_000C, 32'h0000_3020, 32'h11, 32'h22, 32'h33, 2'd1, 1'b0, 5'd0,
                 '{32'h0, BPC_B, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0});

        @(negedge clk);
        bus.stall = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
